// File: rtl/mont_sched_pkg.sv
// Shared types and sizing helpers for the MONT_N_LEN scheduler.
package mont_sched_pkg;

  localparam int W_DEF  = 2048;
  localparam int LW_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KICK = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Watchdog timer width: enough bits to hold TMO itself.
  function automatic int tmr_w(input int tmo);
    return $clog2(tmo + 1);
  endfunction

endpackage

// File: rtl/mont_nlen_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   rr_ptr_i,
  output logic            valid_o,
  output logic [IW-1:0]   g_o
);

  // Scan from the farthest candidate back to the pointer so the nearest hit wins.
  always_comb begin
    int idx;
    valid_o = 1'b0;
    g_o     = '0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_i) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_i[idx]) begin
        valid_o = 1'b1;
        g_o     = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/mont_nlen_sched.sv
// Time-shares one bit-length unit between NREQ requesters with a watchdog.
module mont_nlen_sched
  import mont_sched_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int LW   = LW_DEF,
  parameter int NREQ = 2,
  parameter int TMO  = 4096
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*W-1:0] req_op_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   done_o,
  output logic [LW-1:0]     len_out_o,
  output logic              err_o,
  output logic [W-1:0]      nl_n_o,
  output logic              nl_rst_o,
  input  logic [LW-1:0]     nl_len_i,
  input  logic              nl_finish_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = tmr_w(TMO);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  state_e          state_q;
  logic [IW-1:0]   rr_q, g_q;
  logic [NREQ-1:0] gnt_q, done_q;
  logic [LW-1:0]   len_q;
  logic            err_q, nl_rst_q;
  logic [W-1:0]    nl_n_q;
  logic [TW-1:0]   tmr_q;

  logic            pick_vld;
  logic [IW-1:0]   pick_g;
  logic [W-1:0]    op_sel;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i    (req_i),
    .rr_ptr_i (rr_q),
    .valid_o  (pick_vld),
    .g_o      (pick_g)
  );

  assign op_sel = req_op_i[int'(pick_g)*W +: W];

  // Scheduler FSM; every output is a register so the unit sees clean edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      rr_q     <= '0;
      g_q      <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
      nl_rst_q <= 1'b1;
      nl_n_q   <= '0;
      tmr_q    <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          nl_rst_q <= 1'b1;
          if (pick_vld) begin
            g_q    <= pick_g;
            gnt_q  <= ONE << pick_g;
            nl_n_q <= op_sel;
            if (op_sel != '0) begin
              state_q <= ST_KICK;
            end else begin
              // Zero has length 0; the unit never leaves reset.
              len_q   <= '0;
              err_q   <= 1'b0;
              done_q  <= ONE << pick_g;
              state_q <= ST_DONE;
            end
          end
        end
        ST_KICK: begin
          // Unit has seen a full reset cycle with the new operand; release it.
          nl_rst_q <= 1'b0;
          tmr_q    <= '0;
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          tmr_q <= tmr_q + 1'b1;
          if (nl_finish_i) begin
            len_q    <= nl_len_i;
            err_q    <= 1'b0;
            done_q   <= gnt_q;
            nl_rst_q <= 1'b1;
            state_q  <= ST_DONE;
          end else if (tmr_q == TW'(TMO - 1)) begin
            len_q    <= '0;
            err_q    <= 1'b1;
            done_q   <= gnt_q;
            nl_rst_q <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        default: begin
          gnt_q   <= '0;
          rr_q    <= (g_q == IW'(NREQ - 1)) ? '0 : g_q + 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign len_out_o = len_q;
  assign err_o     = err_q;
  assign nl_n_o    = nl_n_q;
  assign nl_rst_o  = nl_rst_q;

endmodule

// File: tb/tb_mont_nlen_sched.sv
// Bench for mont_nlen_sched: mock bit-length unit, transaction-level schedule model,
// per-cycle compare, directed scenarios with literal expectations, random traffic.
module tb_mont_nlen_sched;

  localparam int W     = 2048;
  localparam int LW    = 12;
  localparam int NREQ  = 2;
  localparam int TMO   = 4096;
  localparam int BOUND = 2 * TMO + 100;
  localparam int NEVER = 32'h7fffffff;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] req_op = '0;
  logic [NREQ-1:0]   gnt, done;
  logic [LW-1:0]     len_out;
  logic              err;
  logic [W-1:0]      nl_n;
  logic              nl_rst;
  logic [LW-1:0]     nl_len;
  logic              nl_finish;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int mock_L = 1;
  int mcnt = 0;

  mont_nlen_sched #(.W(W), .LW(LW), .NREQ(NREQ), .TMO(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_op_i(req_op),
    .gnt_o(gnt), .done_o(done), .len_out_o(len_out), .err_o(err),
    .nl_n_o(nl_n), .nl_rst_o(nl_rst), .nl_len_i(nl_len), .nl_finish_i(nl_finish)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int bitlen(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) if (v[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v = '0;
    if ($urandom_range(0, 3) == 0) return v;
    v[31:0] = $urandom;
    v = v << $urandom_range(0, W - 32);
    return v;
  endfunction

  // Mock unit: length of its operand, finish L cycles into release.
  always @(posedge clk) if (nl_rst) mcnt <= 0; else mcnt <= mcnt + 1;
  always_comb begin
    nl_len    = LW'(bitlen(nl_n));
    nl_finish = !nl_rst && (mcnt + 1 >= mock_L);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endtask

  // Schedule model: one transaction at a time, timing derived from mock latency.
  bit           m_busy = 0, m_zero = 0, m_err = 0, m_err_h = 0;
  int           m_t0 = 0, m_done = 0, m_g = 0, m_rr = 0, m_len = 0, m_len_h = 0;
  logic [W-1:0] m_op = '0, m_nl_n = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0; m_rr = 0; m_len_h = 0; m_err_h = 0; m_nl_n = '0;
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_len", len_out, 0);
        chk("rst_err", err, 0);
        chk("rst_nlrst", nl_rst, 1);
        chk("rst_nl_n_zero", nl_n == '0, 1);
      end else begin
        bit act;
        logic [NREQ-1:0] e_gnt, e_done;
        bit e_rst;
        act    = m_busy && cyc <= m_done;
        e_gnt  = (act && cyc > m_t0) ? NREQ'(1) << m_g : '0;
        e_done = (act && cyc == m_done) ? NREQ'(1) << m_g : '0;
        e_rst  = !(act && !m_zero && cyc >= m_t0 + 2 && cyc < m_done);
        if (act && cyc > m_t0) m_nl_n = m_op;
        if (act && cyc == m_done) begin
          m_len_h = m_len; m_err_h = m_err; m_rr = (m_g + 1) % NREQ;
        end
        chk("gnt", gnt, e_gnt);
        chk("done", done, e_done);
        chk("nl_rst", nl_rst, e_rst);
        chk("len_out", len_out, m_len_h);
        chk("err", err, m_err_h);
        n_chk++;
        if (nl_n !== m_nl_n) begin
          n_fail++;
          if (n_fail <= 30) $display("FAIL nl_n @cyc %0d: got ..%0h, want ..%0h", cyc, nl_n[31:0], m_nl_n[31:0]);
        end
        // An idle cycle with a pending request ends in a grant.
        if (!act && req != '0) begin
          for (int k = NREQ - 1; k >= 0; k--) if (req[(m_rr + k) % NREQ]) m_g = (m_rr + k) % NREQ;
          m_busy = 1;
          m_t0   = cyc;
          m_op   = req_op[m_g*W +: W];
          m_zero = (m_op == '0);
          m_err  = !m_zero && mock_L > TMO;
          m_done = m_zero ? cyc + 1 : cyc + 2 + ((mock_L < TMO) ? mock_L : TMO);
          m_len  = (m_zero || m_err) ? 0 : bitlen(m_op);
        end
      end
    end
  end

  // Requester side: raise requests, drop each on its done, record outcomes.
  int c0;
  int done_at[NREQ], len_at[NREQ], err_at[NREQ];
  logic [NREQ-1:0] gnt_at1;
  bit nlr_low;

  task automatic issue(input logic [NREQ-1:0] rq, input logic [W-1:0] op0, input logic [W-1:0] op1,
                       input int L, input bit rnd);
    logic [NREQ-1:0] pend;
    int k;
    @(posedge clk); #2;
    c0 = cyc; mock_L = L;
    req_op = {op1, op0};
    req = rq; pend = rq; nlr_low = 0; gnt_at1 = '0;
    for (int i = 0; i < NREQ; i++) begin done_at[i] = -1; len_at[i] = 0; err_at[i] = 0; end
    k = 0;
    while (pend != '0 && k < BOUND) begin
      @(posedge clk); #2; k++;
      if (cyc == c0 + 1) gnt_at1 = gnt;
      if (!nl_rst) nlr_low = 1;
      for (int i = 0; i < NREQ; i++) begin
        if (done[i] && pend[i]) begin
          pend[i] = 1'b0; req[i] = 1'b0;
          done_at[i] = cyc; len_at[i] = len_out; err_at[i] = err;
        end else if (rnd && gnt[i]) begin
          if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
          req_op[i*W +: W] = rand_op();
        end
      end
    end
    chk("txn_completes", pend, 0);
    req = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, failures so far %0d", n_fail);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] big;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Simultaneous requests straight out of reset, then again after the pointer wraps.
    for (int r = 0; r < 2; r++) begin
      issue(2'b11, W'(5), W'(256), 4, 0);
      chk("t2_len0", len_at[0], 3);
      chk("t2_len1", len_at[1], 9);
      chk("t2_order", done_at[0] < done_at[1], 1);
      chk("t2_lat0", done_at[0] - c0, 6);
    end

    // Full-width operand, long unit latency.
    big = '0;
    for (int i = 0; i < W / 32; i++) big[i*32 +: 32] = $urandom;
    big[W-1 -: 16] = 16'h81c8;
    big[15:0]      = 16'h1a93;
    issue(2'b01, big, '0, 2048, 0);
    chk("t1_gnt_c1", gnt_at1, 2'b01);
    chk("t1_done_cyc", done_at[0] - c0, 2050);
    chk("t1_len", len_at[0], 2048);
    chk("t1_err", err_at[0], 0);

    // Zero operand: immediate completion, unit stays parked.
    issue(2'b10, W'(9), '0, 3, 0);
    chk("t3_done_cyc", done_at[1] - c0, 1);
    chk("t3_len", len_at[1], 0);
    chk("t3_err", err_at[1], 0);
    chk("t3_nlrst_low", nlr_low, 0);

    // Watchdog expiry.
    issue(2'b01, W'(32'h1234), '0, NEVER, 0);
    chk("t4_done_cyc", done_at[0] - c0, 4098);
    chk("t4_err", err_at[0], 1);
    chk("t4_len", len_at[0], 0);

    // Finish arrives on the last watchdog cycle.
    issue(2'b10, '0, W'(12'habc), TMO, 0);
    chk("t6_done_cyc", done_at[1] - c0, 4098);
    chk("t6_err", err_at[1], 0);
    chk("t6_len", len_at[1], 12);

    // Abort mid-WAIT: requester 1 holds the grant (pointer is 0 now, so serve 0 first).
    issue(2'b01, W'(7), '0, 3, 0);
    @(posedge clk); #2;
    mock_L = 50; req_op = {W'(32'h55), W'(32'h77)}; req = 2'b11;
    repeat (10) @(posedge clk);
    #2;
    chk("t5_granted1", gnt, 2'b10);
    rst_n = 1'b0; req = '0;
    #1;
    chk("t5_gnt_now", gnt, 0);
    chk("t5_nlrst_now", nl_rst, 1);
    chk("t5_done_now", done, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      chk("t5_no_done", done, 0);
    end
    issue(2'b11, W'(5), W'(256), 4, 0);
    chk("t5_rr_reset", done_at[0] < done_at[1], 1);
    chk("t5_len0", len_at[0], 3);

    // Random traffic.
    for (int n = 0; n < 150; n++) begin
      logic [NREQ-1:0] rq;
      rq = NREQ'($urandom_range(1, 3));
      issue(rq, rand_op(), rand_op(), $urandom_range(1, 30), 1);
    end

    repeat (3) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
